// File: rtl/axis_width_upsizer_if.sv
// Stream bundle for the narrow-to-wide packer: narrow s_* input side and wide m_* output side.
// The slave modport is the packer's view; the master modport is the surrounding logic's view.
interface axis_width_upsizer_if #(
   parameter int IN_W  = 8,
   parameter int RATIO = 4
);
   logic [IN_W-1:0]       s_tdata;
   logic                  s_tvalid;
   logic                  s_tlast;
   logic                  s_tready;
   logic [IN_W*RATIO-1:0] m_tdata;
   logic [RATIO-1:0]      m_tkeep;
   logic                  m_tvalid;
   logic                  m_tlast;
   logic                  m_tready;

   modport slave (
      input  s_tdata, s_tvalid, s_tlast, m_tready,
      output s_tready, m_tdata, m_tkeep, m_tvalid, m_tlast
   );

   modport master (
      output s_tdata, s_tvalid, s_tlast, m_tready,
      input  s_tready, m_tdata, m_tkeep, m_tvalid, m_tlast
   );
endinterface

// File: rtl/axis_width_upsizer.sv
// Packs RATIO narrow beats into one wide word with lane keep, framing packets by a
// word counter (PKT_LEN) or an early s_tlast.
module axis_width_upsizer #(
   parameter int IN_W      = 8,
   parameter int RATIO     = 4,
   parameter int PKT_LEN   = 16,
   parameter int MSB_FIRST = 1
)(
   input  logic                 clk,
   input  logic                 rst_n,
   axis_width_upsizer_if.slave  bus,
   output logic [15:0]          o_pkt_cnt
);
   localparam int OUT_W = IN_W * RATIO;
   localparam int BW    = $clog2(RATIO);
   localparam int WW    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

   logic [BW-1:0]    r_bcnt;
   logic [WW-1:0]    r_wcnt;
   logic [OUT_W-1:0] r_acc;
   logic [RATIO-1:0] r_acc_keep;
   logic [OUT_W-1:0] r_m_tdata;
   logic [RATIO-1:0] r_m_tkeep;
   logic             r_m_tvalid;
   logic             r_m_tlast;
   logic [15:0]      r_pkt_cnt;

   logic             w_s_tready;
   logic             w_s_fire;
   logic             w_m_fire;
   logic             w_done;
   logic             w_wlast;
   logic [BW-1:0]    w_lane;
   logic [OUT_W-1:0] w_acc_nxt;
   logic [RATIO-1:0] w_keep_nxt;

   // Ready depends only on registered output state and the downstream ready.
   assign w_s_tready = !r_m_tvalid || bus.m_tready;
   assign w_s_fire   = bus.s_tvalid && w_s_tready;
   assign w_m_fire   = r_m_tvalid && bus.m_tready;
   assign w_lane     = (MSB_FIRST != 0) ? (BW'(RATIO - 1) - r_bcnt) : r_bcnt;
   assign w_done     = w_s_fire && ((r_bcnt == BW'(RATIO - 1)) || bus.s_tlast);
   assign w_wlast    = (r_wcnt == WW'(PKT_LEN - 1)) || bus.s_tlast;

   always_comb begin
      w_acc_nxt  = r_acc;
      w_keep_nxt = r_acc_keep;
      for (int i = 0; i < RATIO; i++) begin
         if (w_lane == BW'(i)) begin
            w_acc_nxt[i*IN_W +: IN_W] = bus.s_tdata;
            w_keep_nxt[i]             = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bcnt     <= '0;
         r_wcnt     <= '0;
         r_acc      <= '0;
         r_acc_keep <= '0;
         r_m_tdata  <= '0;
         r_m_tkeep  <= '0;
         r_m_tvalid <= 1'b0;
         r_m_tlast  <= 1'b0;
         r_pkt_cnt  <= '0;
      end else begin
         if (w_m_fire) begin
            r_m_tvalid <= 1'b0;
            if (r_m_tlast) r_pkt_cnt <= r_pkt_cnt + 16'd1;
         end
         // A completing beat is only accepted when the output slot is free or draining,
         // so loading here never overwrites an untransferred word.
         if (w_done) begin
            r_m_tdata  <= w_acc_nxt;
            r_m_tkeep  <= w_keep_nxt;
            r_m_tlast  <= w_wlast;
            r_m_tvalid <= 1'b1;
            r_acc      <= '0;
            r_acc_keep <= '0;
            r_bcnt     <= '0;
            r_wcnt     <= w_wlast ? '0 : r_wcnt + WW'(1);
         end else if (w_s_fire) begin
            r_acc      <= w_acc_nxt;
            r_acc_keep <= w_keep_nxt;
            r_bcnt     <= r_bcnt + BW'(1);
         end
      end
   end

   assign bus.s_tready = w_s_tready;
   assign bus.m_tdata  = r_m_tdata;
   assign bus.m_tkeep  = r_m_tkeep;
   assign bus.m_tvalid = r_m_tvalid;
   assign bus.m_tlast  = r_m_tlast;
   assign o_pkt_cnt    = r_pkt_cnt;
endmodule

// File: tb/tb_axis_width_upsizer.sv
// Randomised and directed bench for the stream packer; a queue-based packet model predicts
// every output word, and a second instance covers the lane-0-first ordering.
module tb_axis_width_upsizer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] pkt0, pkt1;

   always #5 clk = ~clk;

   axis_width_upsizer_if #(.IN_W(8), .RATIO(4)) bus0();
   axis_width_upsizer_if #(.IN_W(8), .RATIO(4)) bus1();

   axis_width_upsizer #(.IN_W(8), .RATIO(4), .PKT_LEN(16), .MSB_FIRST(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0), .o_pkt_cnt(pkt0));
   axis_width_upsizer #(.IN_W(8), .RATIO(4), .PKT_LEN(16), .MSB_FIRST(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1), .o_pkt_cnt(pkt1));

   typedef struct packed { logic [7:0] d; logic l; } beat_t;
   typedef struct packed { logic [31:0] d; logic [3:0] k; logic l; } word_t;

   beat_t       src_q[$], pend_q[$];
   word_t       exp_q[$], obs_q[$];
   beat_t       cur;
   bit          cur_v = 0, stall_prev = 0;
   word_t       held;
   int          n_cmp = 0, n_bad = 0;
   int          words_in_pkt = 0, n_model = 0;
   int          vld_pct = 100, rdy_pct = 100;
   logic [15:0] exp_pkt = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
      end
   endtask

   // Packet model: gather beats into words of up to 4 lanes, first beat in the top lane.
   function automatic void model_push(beat_t b);
      word_t w;
      pend_q.push_back(b);
      if (pend_q.size() == 4 || b.l) begin
         w = '0;
         foreach (pend_q[j]) begin
            w.d[(3-j)*8 +: 8] = pend_q[j].d;
            w.k[3-j]          = 1'b1;
         end
         words_in_pkt++;
         w.l = b.l || (words_in_pkt == 16);
         if (w.l) words_in_pkt = 0;
         exp_q.push_back(w);
         n_model++;
         pend_q.delete();
      end
   endfunction

   task automatic push_beat(input logic [7:0] d, input logic l);
      beat_t b;
      b.d = d;
      b.l = l;
      src_q.push_back(b);
   endtask

   task automatic tick();
      word_t o, e;
      @(negedge clk);
      if (!cur_v && src_q.size() > 0 && $urandom_range(99) < vld_pct) begin
         cur   = src_q.pop_front();
         cur_v = 1;
      end
      bus0.s_tvalid = cur_v;
      bus0.s_tdata  = cur_v ? cur.d : 8'($urandom);
      bus0.s_tlast  = cur_v ? cur.l : 1'($urandom);
      bus0.m_tready = ($urandom_range(99) < rdy_pct);
      #1;
      o.d = bus0.m_tdata;
      o.k = bus0.m_tkeep;
      o.l = bus0.m_tlast;
      chk("pkt_cnt", pkt0, exp_pkt);
      chk("s_tready", bus0.s_tready, !bus0.m_tvalid || bus0.m_tready);
      if (stall_prev) begin
         chk("stall_valid", bus0.m_tvalid, 1);
         chk("stall_word", o, held);
      end
      if (bus0.m_tvalid && bus0.m_tready) begin
         chk("word_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("word_data", o.d, e.d);
            chk("word_keep", o.k, e.k);
            chk("word_last", o.l, e.l);
            if (e.l) exp_pkt++;
         end
         obs_q.push_back(o);
      end
      stall_prev = bus0.m_tvalid && !bus0.m_tready;
      held       = o;
      if (cur_v && bus0.s_tready) begin
         model_push(cur);
         cur_v = 0;
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((src_q.size() > 0 || cur_v || exp_q.size() > 0 || bus0.m_tvalid) && n < budget) begin
         tick();
         n++;
      end
      chk("drain_in_budget", n < budget, 1);
   endtask

   initial begin
      logic [7:0]  v3 [3];
      logic [15:0] p0;
      int          nl, nm0;
      v3 = '{8'h11, 8'h22, 8'h33};
      bus0.s_tvalid = 0; bus0.s_tdata = '0; bus0.s_tlast = 0; bus0.m_tready = 0;
      bus1.s_tvalid = 0; bus1.s_tdata = '0; bus1.s_tlast = 0; bus1.m_tready = 0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_tvalid", bus0.m_tvalid, 0);
      chk("rst_tlast", bus0.m_tlast, 0);
      chk("rst_tdata", bus0.m_tdata, 0);
      chk("rst_tkeep", bus0.m_tkeep, 0);
      chk("rst_pkt", pkt0, 0);
      chk("rst_tvalid1", bus1.m_tvalid, 0);
      @(negedge clk);
      rst_n = 1;

      // 1: 64 ascending beats, packet closed by the word counter
      obs_q.delete();
      for (int i = 0; i < 64; i++) push_beat(8'(i), 1'b0);
      drain(300);
      tick();
      chk("t1_words", obs_q.size(), 16);
      if (obs_q.size() == 16) begin
         chk("t1_first", obs_q[0].d, 32'h00010203);
         chk("t1_w15_last", obs_q[14].l, 0);
         chk("t1_w16", obs_q[15].d, 32'h3C3D3E3F);
         chk("t1_w16_keep", obs_q[15].k, 4'hF);
         chk("t1_w16_last", obs_q[15].l, 1);
      end
      chk("t1_pkt", pkt0, 16'd1);

      // 2: early s_tlast leaves a partial second word
      obs_q.delete();
      for (int i = 0; i < 6; i++) push_beat(8'hA0 + 8'(i), i == 5);
      drain(100);
      chk("t2_words", obs_q.size(), 2);
      if (obs_q.size() == 2) begin
         chk("t2_w0", obs_q[0].d, 32'hA0A1A2A3);
         chk("t2_w0_keep", obs_q[0].k, 4'hF);
         chk("t2_w0_last", obs_q[0].l, 0);
         chk("t2_w1", obs_q[1].d, 32'hA4A50000);
         chk("t2_w1_keep", obs_q[1].k, 4'hC);
         chk("t2_w1_last", obs_q[1].l, 1);
      end

      // 3: lane-0-first instance, three beats with s_tlast
      bus1.m_tready = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus1.s_tvalid = 1;
         bus1.s_tdata  = v3[i];
         bus1.s_tlast  = (i == 2);
      end
      @(negedge clk);
      bus1.s_tvalid = 0;
      bus1.s_tlast  = 0;
      #1;
      chk("t3_valid", bus1.m_tvalid, 1);
      chk("t3_data", bus1.m_tdata, 32'h00332211);
      chk("t3_keep", bus1.m_tkeep, 4'h7);
      chk("t3_last", bus1.m_tlast, 1);
      @(negedge clk);
      #1;
      chk("t3_pkt", pkt1, 16'd1);
      chk("t3_idle", bus1.m_tvalid, 0);

      // 5: s_tlast coinciding with the 16th word gives a single m_tlast
      obs_q.delete();
      p0 = pkt0;
      for (int i = 0; i < 64; i++) push_beat(8'($urandom), i == 63);
      drain(300);
      tick();
      nl = 0;
      foreach (obs_q[i]) if (obs_q[i].l) nl++;
      chk("t5_words", obs_q.size(), 16);
      chk("t5_nlast", nl, 1);
      if (obs_q.size() == 16) chk("t5_w16_last", obs_q[15].l, 1);
      chk("t5_pkt", pkt0, p0 + 16'd1);

      // 4: random valid gaps, random backpressure, random packet lengths
      obs_q.delete();
      nm0 = n_model;
      vld_pct = 70;
      rdy_pct = 50;
      for (int i = 0; i < 1000; i++) push_beat(8'($urandom), (i == 999) || ($urandom_range(99) < 8));
      drain(20000);
      chk("t4_words", obs_q.size(), n_model - nm0);
      vld_pct = 100;
      rdy_pct = 100;

      // 6: reset mid-word discards the partial accumulator
      push_beat(8'h55, 1'b0);
      push_beat(8'h66, 1'b0);
      drain(50);
      @(negedge clk);
      rst_n = 0;
      bus0.s_tvalid = 0;
      #1;
      chk("t6_rst_tvalid", bus0.m_tvalid, 0);
      chk("t6_rst_tdata", bus0.m_tdata, 0);
      chk("t6_rst_tkeep", bus0.m_tkeep, 0);
      chk("t6_rst_tlast", bus0.m_tlast, 0);
      chk("t6_rst_pkt", pkt0, 0);
      pend_q.delete();
      exp_q.delete();
      obs_q.delete();
      words_in_pkt = 0;
      exp_pkt = '0;
      stall_prev = 0;
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 4; i++) push_beat(8'h10 + 8'(i), 1'b0);
      drain(50);
      chk("t6_words", obs_q.size(), 1);
      if (obs_q.size() == 1) begin
         chk("t6_data", obs_q[0].d, 32'h10111213);
         chk("t6_keep", obs_q[0].k, 4'hF);
         chk("t6_last", obs_q[0].l, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
